// File: rtl/serial_rx_port.sv
// Slave-side serial receiver: valid/ready handshake, then serial address
// (and data for writes) capture with an atomic parallel output update.
module serial_rx_port #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8,
   parameter int MSB_FIRST  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_address,
   input  logic                  rx_data,
   input  logic                  master_valid,
   input  logic                  read_en,
   input  logic                  write_en,
   output logic                  slave_ready,
   output logic                  rx_done,
   output logic                  rx_error,
   output logic                  rx_write,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] data
);

   localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CW   = $clog2(MAXW + 1);
   localparam logic [CW-1:0] LAST_RD = CW'(ADDR_WIDTH - 1);
   localparam logic [CW-1:0] LAST_WR = CW'(MAXW - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nx;
   logic                  r_mode;
   logic [CW-1:0]         r_cnt;
   logic [ADDR_WIDTH-1:0] r_addr_sh;
   logic [DATA_WIDTH-1:0] r_data_sh;
   logic                  r_done;
   logic                  r_error;
   logic                  r_write;
   logic [ADDR_WIDTH-1:0] r_address;
   logic [DATA_WIDTH-1:0] r_data;

   logic                  w_hs;
   logic                  w_at_last;
   logic                  w_sample;
   logic                  w_done_nx;
   logic                  w_error_nx;
   logic [ADDR_WIDTH-1:0] w_addr_nx;
   logic [DATA_WIDTH-1:0] w_data_nx;

   assign w_hs      = (r_state == ST_IDLE) && master_valid && (read_en ^ write_en);
   assign w_at_last = (r_cnt == (r_mode ? LAST_WR : LAST_RD));

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Next-state logic; a dropped master_valid at any sampling edge aborts
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_hs) w_state_nx = ST_RECV;
            else      w_state_nx = ST_IDLE;
         end
         ST_RECV: begin
            if (!master_valid)  w_state_nx = ST_IDLE;
            else if (w_at_last) w_state_nx = ST_DONE;
            else                w_state_nx = ST_RECV;
         end
         ST_DONE: w_state_nx = ST_IDLE;
         default: w_state_nx = ST_IDLE;
      endcase
   end

   // Output/strobe decode feeding the registered outputs
   always_comb begin
      w_sample   = 1'b0;
      w_done_nx  = 1'b0;
      w_error_nx = 1'b0;
      case (r_state)
         ST_RECV: begin
            w_sample   = master_valid;
            w_done_nx  = master_valid && w_at_last;
            w_error_nx = !master_valid;
         end
         default: begin
            w_sample   = 1'b0;
            w_done_nx  = 1'b0;
            w_error_nx = 1'b0;
         end
      endcase
   end

   // Place the current serial bit into its field position (bits past a field's width fall off)
   always_comb begin
      w_addr_nx = r_addr_sh;
      w_data_nx = r_data_sh;
      for (int i = 0; i < ADDR_WIDTH; i++) begin
         if (r_cnt == CW'((MSB_FIRST != 0) ? (ADDR_WIDTH - 1 - i) : i)) w_addr_nx[i] = rx_address;
         else                                                          w_addr_nx[i] = r_addr_sh[i];
      end
      for (int j = 0; j < DATA_WIDTH; j++) begin
         if (r_mode && (r_cnt == CW'((MSB_FIRST != 0) ? (DATA_WIDTH - 1 - j) : j))) w_data_nx[j] = rx_data;
         else                                                                     w_data_nx[j] = r_data_sh[j];
      end
   end

   // Datapath: shift registers, bit counter, and atomically updated outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mode    <= 1'b0;
         r_cnt     <= '0;
         r_addr_sh <= '0;
         r_data_sh <= '0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
         r_write   <= 1'b0;
         r_address <= '0;
         r_data    <= '0;
      end else begin
         r_done  <= w_done_nx;
         r_error <= w_error_nx;
         if (w_hs) begin
            r_mode    <= write_en;
            r_cnt     <= '0;
            r_addr_sh <= '0;
            r_data_sh <= '0;
         end else if (w_sample) begin
            r_addr_sh <= w_addr_nx;
            r_data_sh <= w_data_nx;
            if (!w_at_last) r_cnt <= r_cnt + CW'(1);
         end
         if (w_done_nx) begin
            r_address <= w_addr_nx;
            r_write   <= r_mode;
            if (r_mode) r_data <= w_data_nx;
         end
      end
   end

   assign slave_ready = (r_state == ST_IDLE) && !reset;
   assign rx_done     = r_done;
   assign rx_error    = r_error;
   assign rx_write    = r_write;
   assign address     = r_address;
   assign data        = r_data;

endmodule

// File: doc/serial_rx_port.md
Name: serial_rx_port

Overview:
Parametrised serial receiver for the slave side of the bus. Captures a serially transferred address and, for writes, a serially transferred data word from the master after a valid/ready handshake. Supports configurable address width, data width and bit order. Adds read/write mode capture, abort-on-valid-drop, and atomic parallel output update. Sits between the bus interconnect and the slave memory/controller.

Parameters:
ADDR_WIDTH, 12, address bits received per transfer (>=1)
DATA_WIDTH, 8, data bits received per write transfer (>=1)
MSB_FIRST, 0, 0 = LSB transmitted first, 1 = MSB transmitted first

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous active-high reset
rx_address  input  1  serial address bit from master
rx_data  input  1  serial data bit from master
master_valid  input  1  master requests/holds a transfer
read_en  input  1  transfer is a read (address only)
write_en  input  1  transfer is a write (address + data)
slave_ready  output  1  high only in IDLE
rx_done  output  1  one-cycle pulse: transfer complete, outputs updated
rx_error  output  1  one-cycle pulse: transfer aborted
rx_write  output  1  mode of last completed transfer (1 = write)
address  output  ADDR_WIDTH  last completed address
data  output  DATA_WIDTH  last completed write data

Behaviour:
- Reset (async, any state): state IDLE, bit counter 0, shift registers 0; address=0, data=0, rx_write=0, rx_done=0, rx_error=0; slave_ready=1 once reset is released.
- Handshake: cycle H with state IDLE, master_valid=1, and exactly one of read_en/write_en high. If both or neither are high, no handshake occurs and the block stays in IDLE.
- At the H edge:
  - latch mode (write_en)
  - clear counter
  - go to RECV
  - set L = ADDR_WIDTH for reads, max(ADDR_WIDTH, DATA_WIDTH) for writes
- RECV timing:
  - Master drives bit k (k=0..L-1) on rx_address/rx_data during cycle H+1+k.
  - The block samples at the end of that cycle.
  - Address bits with k>=ADDR_WIDTH are ignored; data bits with k>=DATA_WIDTH are ignored; rx_data is ignored entirely for reads.
- Bit placement:
  - MSB_FIRST=0: bit k goes to position k.
  - MSB_FIRST=1: bit k goes to position WIDTH-1-k of the respective field.
- Internal shift registers only. Outputs address/data/rx_write do not change during RECV.
- After sampling bit L-1 (edge ending cycle H+L), go to DONE. In cycle H+L+1:
  - rx_done=1
  - address updated
  - data updated (writes only; reads leave data unchanged)
  - rx_write updated
- DONE -> IDLE unconditionally. slave_ready=1 from cycle H+L+2. Back-to-back transfers are allowed from that cycle.
- Latency: handshake to rx_done = L+1 cycles (13 for a 12-bit read).
- Abort: if master_valid=0 at any RECV sampling edge:
  - that bit is discarded
  - go to IDLE
  - rx_error=1 for exactly the next cycle (slave_ready=1 in that same cycle)
  - address/data/rx_write keep their previous values
  - no rx_done pulse
- read_en/write_en changes during RECV are ignored; mode is fixed at handshake.
- rx_done and rx_error are never high simultaneously. Both are registered outputs.
- Counter width: $clog2(max(ADDR_WIDTH,DATA_WIDTH)+1). The counter never wraps; the terminal count is L-1.

Test Plan:
- Write, defaults, LSB first: handshake with write_en=1, serial address 0xA5C, data 0x3E -> rx_done high exactly 13 cycles after handshake; address=0xA5C, data=0x3E, rx_write=1; slave_ready=0 for cycles H+1..H+13 and 1 at H+14.
- Read after that write: read_en=1, address 0x123, rx_data toggling -> rx_done at H+13; address=0x123, data stays 0x3E, rx_write=0.
- Abort: write started, master_valid dropped during cycle H+5 -> rx_error pulse in cycle H+6, no rx_done; address/data unchanged; a new write handshake at H+6 completes normally.
- Illegal mode: master_valid=1 with read_en=write_en=1 (and again with both 0) for 20 cycles -> slave_ready stays 1, no rx_done/rx_error, outputs unchanged.
- Reset mid-transfer: assert reset asynchronously between edges at H+7 -> all outputs 0 immediately, state IDLE; a following write of address 0x001 / data 0x80 completes correctly.
- Parameter variant ADDR_WIDTH=4, DATA_WIDTH=8, MSB_FIRST=1: write address 0x9, data 0xC3 sent MSB first -> rx_done at H+9; address=0x9, data=0xC3. A read of the same address gives rx_done at H+5.
